// File: rtl/err_stat_acc.sv
// Windowed slicer-error statistics: per-window mean of err^2 or err, plus peak |err|.
// Results are published with a one-cycle valid strobe at each window end.
module err_stat_acc #(
  parameter int DATA_W = 18,
  parameter int LOG2_N = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              hold,
  input  logic              mode,
  input  logic [DATA_W-1:0] err,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] peak_out,
  output logic              result_valid,
  output logic              mode_out,
  output logic [CNT_W-1:0]  window_cnt
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int SQ_W  = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [SQ_W-1:0]   sq_s;
  logic [DATA_W-1:0]        mse_term_s;
  logic [DATA_W-1:0]        mag_s;
  logic [DATA_W-1:0]        peak_nxt_s;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic                     win_end_s;
  logic                     unused_sq_s;

  logic signed [ACC_W-1:0]  acc_q,       acc_d;
  logic [LOG2_N-1:0]        smp_cnt_q,   smp_cnt_d;
  logic [DATA_W-1:0]        peak_reg_q,  peak_reg_d;
  logic                     mode_act_q,  mode_act_d;
  logic [DATA_W-1:0]        result_q,    result_d;
  logic [DATA_W-1:0]        peak_out_q,  peak_out_d;
  logic                     valid_q,     valid_d;
  logic                     mode_out_q,  mode_out_d;
  logic [CNT_W-1:0]         win_cnt_q,   win_cnt_d;

  // |e| with the most negative code clamped to full-scale positive
  function automatic logic [DATA_W-1:0] sat_mag(input logic [DATA_W-1:0] e);
    logic [DATA_W-1:0] r;
    if (e == MIN_NEG) begin
      r = MAX_POS;
    end else if (e[DATA_W-1]) begin
      r = (~e) + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = e;
    end
    return r;
  endfunction

  // Only (-1.0)^2 sets the integer bit of the product; clamp it so the term stays positive
  function automatic logic [DATA_W-1:0] sat_sq_term(input logic signed [SQ_W-1:0] sq);
    logic [DATA_W-1:0] r;
    if (sq[SQ_W-2]) begin
      r = MAX_POS;
    end else begin
      r = sq[SQ_W-2:DATA_W-1];
    end
    return r;
  endfunction

  assign sq_s        = $signed(err) * $signed(err);
  assign unused_sq_s = ^{sq_s[SQ_W-1], sq_s[DATA_W-2:0]};
  assign mse_term_s  = sat_sq_term(sq_s);
  assign mag_s       = sat_mag(err);
  assign peak_nxt_s  = (mag_s > peak_reg_q) ? mag_s : peak_reg_q;
  assign win_end_s   = (smp_cnt_q == {LOG2_N{1'b1}});

  // Per-sample term selected by the mode latched for this window
  always_comb begin
    term_s = {ACC_W{1'b0}};
    if (mode_act_q) begin
      term_s = {{LOG2_N{err[DATA_W-1]}}, err};
    end else begin
      term_s = {{LOG2_N{1'b0}}, mse_term_s};
    end
  end

  assign sum_s = acc_q + term_s;

  // Next-state: hold restarts the window, an accepted sample accumulates or closes it
  always_comb begin
    acc_d      = acc_q;
    smp_cnt_d  = smp_cnt_q;
    peak_reg_d = peak_reg_q;
    mode_act_d = mode_act_q;
    result_d   = result_q;
    peak_out_d = peak_out_q;
    valid_d    = 1'b0;
    mode_out_d = mode_out_q;
    win_cnt_d  = win_cnt_q;
    if (hold) begin
      acc_d      = {ACC_W{1'b0}};
      smp_cnt_d  = {LOG2_N{1'b0}};
      peak_reg_d = {DATA_W{1'b0}};
      mode_act_d = mode;
    end else if (clk_en) begin
      if (win_end_s) begin
        // Dropping the low LOG2_N bits of a signed sum floors toward -inf
        result_d   = sum_s[ACC_W-1:LOG2_N];
        peak_out_d = peak_nxt_s;
        mode_out_d = mode_act_q;
        valid_d    = 1'b1;
        win_cnt_d  = win_cnt_q + CNT_W'(1);
        acc_d      = {ACC_W{1'b0}};
        smp_cnt_d  = {LOG2_N{1'b0}};
        peak_reg_d = {DATA_W{1'b0}};
        mode_act_d = mode;
      end else begin
        acc_d      = sum_s;
        smp_cnt_d  = smp_cnt_q + LOG2_N'(1);
        peak_reg_d = peak_nxt_s;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= {ACC_W{1'b0}};
      smp_cnt_q  <= {LOG2_N{1'b0}};
      peak_reg_q <= {DATA_W{1'b0}};
      mode_act_q <= 1'b0;
      result_q   <= {DATA_W{1'b0}};
      peak_out_q <= {DATA_W{1'b0}};
      valid_q    <= 1'b0;
      mode_out_q <= 1'b0;
      win_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      acc_q      <= acc_d;
      smp_cnt_q  <= smp_cnt_d;
      peak_reg_q <= peak_reg_d;
      mode_act_q <= mode_act_d;
      result_q   <= result_d;
      peak_out_q <= peak_out_d;
      valid_q    <= valid_d;
      mode_out_q <= mode_out_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

  assign result_out   = result_q;
  assign peak_out     = peak_out_q;
  assign result_valid = valid_q;
  assign mode_out     = mode_out_q;
  assign window_cnt   = win_cnt_q;

endmodule
